// File: rtl/rv0_imem_ahb.sv
// rv0_imem_ahb: AHB-Lite read-only instruction memory subordinate in front of a 1-cycle-latency SRAM/ROM,
// with configurable OKAY wait states and a two-cycle ERROR response for illegal accesses.
module rv0_imem_ahb #(
  parameter int          XLEN        = 32,
  parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
  parameter int          MEM_DEPTH   = 4096,
  parameter int          WAIT_STATES = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         hsel_i,
  input  logic [XLEN-1:0]              haddr_i,
  input  logic [1:0]                   htrans_i,
  input  logic                         hwrite_i,
  input  logic [2:0]                   hsize_i,
  input  logic                         hready_i,
  output logic                         hreadyout_o,
  output logic                         hresp_o,
  output logic [31:0]                  hrdata_o,
  output logic                         mem_req_o,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr_o,
  input  logic [31:0]                  mem_rdata_i
);
  localparam int AW = $clog2(MEM_DEPTH);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
  state_t          r_state, w_next;
  logic [2:0]      r_cnt;
  logic [31:0]     r_rdata;
  logic            w_rdy, w_acc, w_legal;
  logic [XLEN-1:0] w_off;
  assign w_rdy   = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
  assign w_acc   = hsel_i && (htrans_i inside {2'b10, 2'b11}) && hready_i && w_rdy;
  assign w_off   = haddr_i - MEM_BASE;
  // the offset is only trusted once haddr_i >= MEM_BASE, so an address below the window never wraps in
  assign w_legal = !hwrite_i && (hsize_i == 3'b010) && (haddr_i[1:0] == 2'b00) &&
                   (haddr_i >= MEM_BASE) && (64'(w_off) < 64'(MEM_DEPTH) * 64'd4);
  assign mem_req_o   = w_acc && w_legal;
  assign mem_addr_o  = w_off[AW+1:2];
  assign hreadyout_o = w_rdy;
  assign hresp_o     = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign hrdata_o    = (r_state == S_DATA) ? ((WAIT_STATES == 0) ? mem_rdata_i : r_rdata) : 32'h0;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT:  w_next = (r_cnt == 3'd1) ? S_DATA : S_WAIT;
      S_ERR1:  w_next = S_ERR2;
      default: w_next = !w_acc ? S_IDLE : !w_legal ? S_ERR1 : (WAIT_STATES == 0) ? S_DATA : S_WAIT;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_rdata <= 32'h0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_rdy && w_next == S_WAIT) ? 3'(WAIT_STATES) : (r_state == S_WAIT) ? r_cnt - 3'd1 : r_cnt;
      // SRAM data is only guaranteed on the first data cycle, so hold it for the rest of the wait
      if (r_state == S_WAIT && r_cnt == 3'(WAIT_STATES)) r_rdata <= mem_rdata_i;
    end
  end
endmodule

// File: tb/tb_rv0_imem_ahb.sv
// tb_rv0_imem_ahb: three instruction-memory subordinates (0, 2 and 3 wait states, one with a non-zero base)
// driven by an AHB manager model and checked per transfer against a word-array memory model.
module tb_rv0_imem_ahb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel[3], hwrite[3], hready[3], hreadyout[3], hresp[3], mem_req[3];
  logic [31:0] haddr[3], hrdata[3], sram_q[3];
  logic [1:0]  htrans[3];
  logic [2:0]  hsize[3];
  logic [11:0] mem_addr[3];
  logic [31:0] mem[3][4096];
  logic [31:0] q_a[$];
  bit          q_w[$];
  logic [2:0]  q_s[$];
  int          n_cmp = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gd
      assign hready[g] = hreadyout[g];
      always @(posedge clk) if (mem_req[g]) sram_q[g] <= mem[g][mem_addr[g]];
      rv0_imem_ahb #(
        .XLEN(32), .MEM_BASE(g == 2 ? 32'h2000_0000 : 32'h0), .MEM_DEPTH(4096),
        .WAIT_STATES(g == 0 ? 0 : g == 1 ? 2 : 3)
      ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .hsel_i(hsel[g]), .haddr_i(haddr[g]), .htrans_i(htrans[g]),
        .hwrite_i(hwrite[g]), .hsize_i(hsize[g]), .hready_i(hready[g]), .hreadyout_o(hreadyout[g]),
        .hresp_o(hresp[g]), .hrdata_o(hrdata[g]), .mem_req_o(mem_req[g]), .mem_addr_o(mem_addr[g]),
        .mem_rdata_i(sram_q[g])
      );
    end
  endgenerate
  function automatic int ws_of(int k);
    return k == 0 ? 0 : k == 1 ? 2 : 3;
  endfunction
  function automatic logic [31:0] base_of(int k);
    return k == 2 ? 32'h2000_0000 : 32'h0;
  endfunction
  function automatic bit legal_of(int k, logic [31:0] a, bit w, logic [2:0] s);
    return !w && s == 3'b010 && a[1:0] == 2'b00 && a >= base_of(k) && (a - base_of(k)) < 32'h4000;
  endfunction
  task automatic push(logic [31:0] a, bit w, logic [2:0] s);
    q_a.push_back(a);
    q_w.push_back(w);
    q_s.push_back(s);
  endtask
  task automatic bus_idle(int k);
    hsel[k] = 1'b0; htrans[k] = 2'b00; hwrite[k] = 1'b0; hsize[k] = 3'b010;
  endtask
  // Issues the queued transfers as a pipelined burst and checks every cycle of every data phase.
  task automatic run(int k, string nm);
    int n = q_a.size();
    int idx = 0, d = -1, lowc = 0, cyc = 0;
    bit rdy, ok, ereq;
    logic [31:0] exp_d;
    while ((idx < n || d >= 0) && cyc < 2000) begin
      @(posedge clk); #1; cyc++;
      if (idx < n) begin
        hsel[k] = 1'b1; htrans[k] = (idx == 0) ? 2'b10 : 2'b11;
        haddr[k] = q_a[idx]; hwrite[k] = q_w[idx]; hsize[k] = q_s[idx];
      end else bus_idle(k);
      @(negedge clk);
      rdy = hreadyout[k];
      if (d >= 0) begin
        ok = legal_of(k, q_a[d], q_w[d], q_s[d]);
        if (!rdy) begin
          lowc++;
          n_cmp++;
          if (hresp[k] !== !ok) begin n_err++; $display("FAIL %s wait_resp k=%0d xfer=%0d: got %0b want %0b", nm, k, d, hresp[k], !ok); end
        end else begin
          exp_d = ok ? mem[k][int'((q_a[d] - base_of(k)) >> 2)] : 32'h0;
          n_cmp++;
          if (lowc != (ok ? ws_of(k) : 1)) begin n_err++; $display("FAIL %s low_cycles k=%0d xfer=%0d: got %0d want %0d", nm, k, d, lowc, ok ? ws_of(k) : 1); end
          n_cmp++;
          if (hresp[k] !== !ok) begin n_err++; $display("FAIL %s hresp k=%0d xfer=%0d: got %0b want %0b", nm, k, d, hresp[k], !ok); end
          n_cmp++;
          if (hrdata[k] !== exp_d) begin n_err++; $display("FAIL %s hrdata k=%0d xfer=%0d: got %08h want %08h", nm, k, d, hrdata[k], exp_d); end
          d = -1; lowc = 0;
        end
      end else begin
        n_cmp++;
        if (rdy !== 1'b1 || hresp[k] !== 1'b0 || hrdata[k] !== 32'h0) begin
          n_err++; $display("FAIL %s idle k=%0d: got rdy=%0b resp=%0b data=%08h want 1/0/0", nm, k, rdy, hresp[k], hrdata[k]);
        end
      end
      ereq = rdy && idx < n && legal_of(k, q_a[idx], q_w[idx], q_s[idx]);
      n_cmp++;
      if (mem_req[k] !== ereq) begin n_err++; $display("FAIL %s mem_req k=%0d: got %0b want %0b", nm, k, mem_req[k], ereq); end
      if (ereq) begin
        n_cmp++;
        if (mem_addr[k] !== 12'((q_a[idx] - base_of(k)) >> 2)) begin
          n_err++; $display("FAIL %s mem_addr k=%0d: got %0h want %0h", nm, k, mem_addr[k], 12'((q_a[idx] - base_of(k)) >> 2));
        end
      end
      if (rdy && idx < n) begin d = idx; idx++; end
    end
    n_cmp++;
    if (cyc >= 2000) begin n_err++; $display("FAIL %s timeout k=%0d: got %0d cycles want < 2000", nm, k, cyc); end
    bus_idle(k);
    q_a.delete(); q_w.delete(); q_s.delete();
  endtask
  task automatic test_reset();
    #2;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (hreadyout[k] !== 1'b1 || hresp[k] !== 1'b0 || hrdata[k] !== 32'h0 || mem_req[k] !== 1'b0) begin
        n_err++; $display("FAIL reset k=%0d: got rdy=%0b resp=%0b data=%08h req=%0b want 1/0/0/0", k, hreadyout[k], hresp[k], hrdata[k], mem_req[k]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
  endtask
  task automatic test_back_to_back();
    mem[0][0] = 32'h11; mem[0][1] = 32'h22; mem[0][2] = 32'h33;
    push(32'h0, 0, 3'b010); push(32'h4, 0, 3'b010); push(32'h8, 0, 3'b010);
    run(0, "b2b");
  endtask
  task automatic test_wait_states();
    mem[1][4] = 32'hDEAD_BEEF;
    push(32'h10, 0, 3'b010);
    run(1, "wait");
    push(32'h2000_0100, 0, 3'b010); push(32'h2000_0104, 0, 3'b010);
    run(2, "wait3");
  endtask
  task automatic test_errors();
    push(32'h4000, 0, 3'b010);
    run(0, "range");
    push(32'h2, 0, 3'b010); push(32'h8, 1, 3'b010); push(32'hC, 0, 3'b001); push(32'h10, 0, 3'b010);
    run(0, "attr");
    push(32'h2000_4000, 0, 3'b010); push(32'h1FFF_FFFC, 0, 3'b010); push(32'h2000_3FFC, 0, 3'b010);
    run(2, "base_range");
  endtask
  task automatic test_non_transfers();
    for (int c = 0; c < 15; c++) begin
      int k = c % 3;
      @(posedge clk); #1;
      hsel[k] = (c % 5) != 2; htrans[k] = (c % 5 == 2) ? 2'b10 : 2'((c % 5) & 1);
      haddr[k] = base_of(k) + 32'($urandom_range(0, 4095)) * 4; hwrite[k] = 1'b0; hsize[k] = 3'b010;
      @(negedge clk);
      n_cmp++;
      if (hreadyout[k] !== 1'b1 || hresp[k] !== 1'b0 || mem_req[k] !== 1'b0 || hrdata[k] !== 32'h0) begin
        n_err++; $display("FAIL nontrans k=%0d htrans=%0d: got rdy=%0b resp=%0b req=%0b data=%08h want 1/0/0/0", k, htrans[k], hreadyout[k], hresp[k], mem_req[k], hrdata[k]);
      end
      bus_idle(k);
    end
  endtask
  task automatic test_random(int k);
    for (int i = 0; i < 24; i++) begin
      int r = $urandom_range(0, 9);
      logic [31:0] a = base_of(k) + 32'($urandom_range(0, 4095)) * 4;
      if (r == 6) push(a | 32'($urandom_range(1, 3)), 0, 3'b010);
      else if (r == 7) push(a, 1, 3'b010);
      else if (r == 8) push(a, 0, 3'($urandom_range(0, 1)));
      else if (r == 9) push((k == 2 && i[0]) ? base_of(k) - 32'h4 : a + 32'h4000, 0, 3'b010);
      else push(a, 0, 3'b010);
    end
    run(k, "random");
  endtask
  task automatic test_reset_in_wait();
    @(posedge clk); #1;
    hsel[2] = 1'b1; htrans[2] = 2'b10; haddr[2] = 32'h2000_0000; hwrite[2] = 1'b0; hsize[2] = 3'b010;
    @(negedge clk);
    n_cmp++;
    if (mem_req[2] !== 1'b1) begin n_err++; $display("FAIL rst_wait accept: got req=%0b want 1", mem_req[2]); end
    @(posedge clk); #1; bus_idle(2);
    @(negedge clk);
    n_cmp++;
    if (hreadyout[2] !== 1'b0) begin n_err++; $display("FAIL rst_wait in_wait: got rdy=%0b want 0", hreadyout[2]); end
    rst_n = 1'b0; #1;
    n_cmp++;
    if (hreadyout[2] !== 1'b1 || hresp[2] !== 1'b0 || mem_req[2] !== 1'b0) begin
      n_err++; $display("FAIL rst_wait abort: got rdy=%0b resp=%0b req=%0b want 1/0/0", hreadyout[2], hresp[2], mem_req[2]);
    end
    @(negedge clk); rst_n = 1'b1;
    push(32'h2000_0000, 0, 3'b010);
    run(2, "rst_wait_after");
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      bus_idle(k); haddr[k] = 32'h0;
      for (int i = 0; i < 4096; i++) mem[k][i] = $urandom;
    end
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_errors();
    test_non_transfers();
    for (int k = 0; k < 3; k++) test_random(k);
    test_reset_in_wait();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
